// File: rtl/man_motion.sv
// Per-frame motion controller for the player sprite: owns ManX/ManY and walks
// them one pixel per clock, consulting the wall flags before every pixel.
module man_motion #(
  parameter int X_INIT = 40,
  parameter int Y_INIT = 200,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 459,
  parameter int STEP_X = 2,
  parameter int JUMP_V = 8,
  parameter int G_MAX  = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  input  logic       wall_left,
  input  logic       wall_right,
  input  logic       wall_above,
  output logic [9:0] ManX,
  output logic [9:0] ManY,
  output logic       busy,
  output logic       on_ground,
  output logic [1:0] motion_state,
  output logic       missed_tick,
  output logic [1:0] seq_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HSTEP   = 2'd1;
  localparam logic [1:0] S_VDECIDE = 2'd2;
  localparam logic [1:0] S_VSTEP   = 2'd3;

  localparam logic [1:0] M_GROUND = 2'd0;
  localparam logic [1:0] M_RISE   = 2'd1;
  localparam logic [1:0] M_FALL   = 2'd2;

  localparam logic [9:0] X_INIT_V = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_V = 10'(Y_INIT);
  localparam logic [9:0] X_MAX_V  = 10'(X_MAX);
  localparam logic [9:0] Y_MAX_V  = 10'(Y_MAX);
  localparam logic [3:0] STEP_V   = 4'(STEP_X);
  localparam logic [3:0] JUMP_VV  = 4'(JUMP_V);
  localparam logic [3:0] G_MAX_V  = 4'(G_MAX);

  logic [1:0] seq;
  logic [1:0] motion;
  logic       ml, mr, jmp;
  logic [3:0] hcnt, vcnt, vel;
  logic       go_left, go_right, left_ok, right_ok, fall_stop;
  logic [3:0] vel_fall_next;

  assign go_left   = ml && !mr;
  assign go_right  = mr && !ml;
  assign left_ok   = !wall_left && (ManX != 10'd0);
  assign right_ok  = !wall_right && (ManX < X_MAX_V);
  assign fall_stop = wall_above || (ManY == Y_MAX_V);
  assign vel_fall_next = (vel >= G_MAX_V) ? G_MAX_V : vel + 4'd1;

  assign busy         = (seq != S_IDLE);
  assign on_ground    = (motion == M_GROUND);
  assign motion_state = motion;
  assign seq_state    = seq;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      seq         <= S_IDLE;
      motion      <= M_FALL;
      vel         <= 4'd1;
      vcnt        <= 4'd0;
      hcnt        <= 4'd0;
      ml          <= 1'b0;
      mr          <= 1'b0;
      jmp         <= 1'b0;
      ManX        <= X_INIT_V;
      ManY        <= Y_INIT_V;
      missed_tick <= 1'b0;
    end else begin
      // A tick landing mid-update is dropped; only the pulse records it.
      missed_tick <= frame_tick && (seq != S_IDLE);
      case (seq)
        S_IDLE: begin
          if (frame_tick) begin
            ml   <= move_left;
            mr   <= move_right;
            jmp  <= jump;
            hcnt <= STEP_V;
            seq  <= S_HSTEP;
          end
        end
        S_HSTEP: begin
          if (hcnt == 4'd0) begin
            seq <= S_VDECIDE;
          end else if (go_left && left_ok) begin
            ManX <= ManX - 10'd1;
            hcnt <= hcnt - 4'd1;
          end else if (go_right && right_ok) begin
            ManX <= ManX + 10'd1;
            hcnt <= hcnt - 4'd1;
          end else begin
            hcnt <= 4'd0;
          end
        end
        S_VDECIDE: begin
          seq <= S_VSTEP;
          if (motion == M_GROUND) begin
            if (jmp && wall_above) begin
              motion <= M_RISE;
              vel    <= JUMP_VV;
              vcnt   <= JUMP_VV;
            end else if (!wall_above) begin
              motion <= M_FALL;
              vel    <= 4'd1;
              vcnt   <= 4'd1;
            end else begin
              vcnt <= 4'd0;
            end
          end else begin
            vcnt <= vel;
          end
        end
        default: begin
          if (vcnt == 4'd0) begin
            seq <= S_IDLE;
            if (motion == M_RISE) begin
              if (vel == 4'd1) begin
                motion <= M_FALL;
                vel    <= 4'd1;
              end else begin
                vel <= vel - 4'd1;
              end
            end else if (motion == M_FALL) begin
              vel <= vel_fall_next;
            end
          end else if (motion == M_RISE) begin
            if (ManY == 10'd0) begin
              vcnt <= 4'd0;
            end else begin
              ManY <= ManY - 10'd1;
              vcnt <= vcnt - 4'd1;
            end
          end else if (motion == M_FALL) begin
            // Landing is checked before every pixel so one-row floors hold.
            if (fall_stop) begin
              motion <= M_GROUND;
              vcnt   <= 4'd0;
            end else begin
              ManY <= ManY + 10'd1;
              vcnt <= vcnt - 4'd1;
            end
          end else begin
            vcnt <= 4'd0;
          end
        end
      endcase
    end
  end

endmodule
